dut_stream_fifo: RTL and testbench
==================================

// Module: dut_stream_fifo
//
// PURPOSE
// Synchronous valid/ready stream buffer. It is the DUT stage the top-level bench clocks and
// drives through dut_intf. It accepts words from the interface-side producer and re-presents
// them, in order, to the downstream consumer.
// It decouples producer and consumer timing, and exposes occupancy and flush for directed and
// random checking.
//
// PARAMETERS
// DATA_W    32   width of in_data/out_data in bits
// DEPTH     8    number of storage entries; power of two, >= 2
// AF_LEVEL  6    almost_full asserts when count >= AF_LEVEL; 1..DEPTH
//
// PORTS
// clk           in   1                     single clock; all state on rising edge
// rst_n         in   1                     reset, asynchronous assert, active-low
// flush         in   1                     synchronous clear of all stored words
// in_valid      in   1                     producer word available
// in_ready      out  1                     block can accept a word this cycle
// in_data       in   DATA_W                producer word
// out_valid     out  1                     out_data holds the oldest stored word
// out_ready     in   1                     consumer takes out_data this cycle
// out_data      out  DATA_W                oldest stored word
// count         out  $clog2(DEPTH+1)       number of stored words, 0..DEPTH
// almost_full   out  1                     count >= AF_LEVEL
//
// BEHAVIOUR
// - Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//   rst_n low clears wr_ptr/rd_ptr/count to 0 and forces out_valid=0, almost_full=0, in_ready=0.
//   Storage contents need no reset.
// - Reset release: in_ready=1 from the first edge after rst_n deasserts.
// - Handshakes:
//   push = in_valid & in_ready;  pop = out_valid & out_ready.
//   Sampled only on rising clk with rst_n high.
// - in_ready = (count != DEPTH) & rst_n. It does not depend on out_ready: no combinational
//   in->out path, so there is no push-through when full.
// - out_valid = (count != 0). out_data = mem[rd_ptr], first-word-fall-through.
// - Latency: a word pushed at edge N shows out_valid=1 and its data after edge N.
//   It can be popped at edge N+1 at the earliest.
// - count update:
//   - push only: +1
//   - pop only: -1
//   - push and pop same edge: unchanged, both pointers advance
//   - neither: unchanged
// - Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. Full/empty come from
//   count, never from pointer compare.
// - Ordering: strict FIFO. Every accepted word is presented exactly once and is never
//   duplicated or dropped, except by flush or reset.
// - Producer rules:
//   - in_valid without in_ready: the word is not taken.
//   - The producer must hold in_data stable until accepted; the block does not check this.
// - out_data is held stable while out_valid=1 and out_ready=0.
// - flush=1 at an edge: pointers and count go to 0, and out_valid=0 after the edge.
//   A push or pop in the same cycle is discarded. Flush has priority over push and pop.
// - Full (count==DEPTH): in_ready=0. A pop that cycle makes in_ready=1 after the edge.
// - Empty (count==0): out_valid=0, and out_ready is ignored.
// - Reset mid-transfer: stored words are lost, all outputs drop at once (asynchronous).
//   No partial state survives.
// - almost_full is registered alongside count, i.e. it reflects count after the edge.
//
// TESTING
// 1. Reset: rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, count=0.
//    Release -> in_ready=1, count=0.
// 2. Fill/drain: push 0xA0..0xA7 with out_ready=0 -> count 1..8, almost_full from the 6th
//    push, in_ready=0 at 8.
//    Then out_ready=1 -> data 0xA0..0xA7 in order, count to 0.
// 3. Wrap + simultaneous: 20 words with in_valid=out_ready=1 every cycle -> count steady at 1,
//    all 20 emerge in order, pointers wrap twice.
// 4. Full corner: at count=8 drive push+pop -> push refused, pop taken, count=7, in_ready=1.
//    The next push is accepted.
// 5. Backpressure: out_ready toggling 1/0 with random data -> out_data stable while stalled,
//    scoreboard matches, no loss.
// 6. Flush/reset mid-stream: count=5, flush with in_valid=out_ready=1 -> count=0, out_valid=0,
//    neither word taken.
//    Repeat with rst_n pulse -> same.

Source files
------------

// File: rtl/dut_stream_fifo.sv
// rtl/dut_stream_fifo.sv - valid/ready first-word-fall-through stream FIFO with occupancy and flush
module dut_stream_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_next;
  logic              af_q;
  logic              ready_en;
  logic              push;
  logic              pop;

  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready    = ready_en & (count_q != CW'(DEPTH)) & rst_n;
  assign out_valid   = (count_q != '0);
  assign out_data    = mem[rd_ptr];
  assign count       = count_q;
  assign almost_full = af_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_q + 1'b1;
        2'b01:   count_next = count_q - 1'b1;
        default: count_next = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      count_q  <= count_next;
      af_q     <= (count_next >= CW'(AF_LEVEL));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_dut_stream_fifo.sv
// tb/tb_dut_stream_fifo.sv - randomized scoreboard bench for dut_stream_fifo
module tb_dut_stream_fifo;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int CW       = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic              almost_full;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit alive = 1'b0;

  dut_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words, advanced once per cycle
  always @(negedge clk) begin
    int sz;
    bit exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
      alive = 1'b0;
    end
    sz = exp_q.size();
    exp_rdy = alive && (sz < DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, sz != 0);
    chk("count", count, sz);
    chk("almost_full", almost_full, sz >= AF_LEVEL);
    if (sz != 0) chk("out_data", out_data, exp_q[0]);
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && sz != 0) void'(exp_q.pop_front());
        if (in_valid && exp_rdy) exp_q.push_back(in_data);
      end
    end
    alive = rst_n;
  end

  task automatic drive(input bit iv, input logic [DATA_W-1:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_count", count, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle(2);
    chk("release_in_ready", in_ready, 1'b1);

    // fill to full, extra push refused, then drain in order
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hA0 + i, 1'b0, 1'b0);
    drive(1'b1, 32'hFF, 1'b0, 1'b0);
    drain(10);

    // simultaneous push/pop, pointers wrap
    for (int i = 0; i < 20; i++) drive(1'b1, 32'hB0 + i, 1'b1, 1'b0);
    drain(3);

    // full corner: push refused while pop taken
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hC0 + i, 1'b0, 1'b0);
    drive(1'b1, 32'hC8, 1'b1, 1'b0);
    drive(1'b1, 32'hC9, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("corner_count", count, 8);
    drain(10);

    // backpressure with random traffic
    for (int i = 0; i < 300; i++) drive($urandom_range(0, 3) != 0, $urandom, i[0], 1'b0);
    drain(10);

    // flush mid-stream
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hD0 + i, 1'b0, 1'b0);
    drive(1'b1, 32'hD5, 1'b1, 1'b1);
    idle(1);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    idle(2);

    // reset mid-stream
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hE0 + i, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hF0 + i, $urandom_range(0, 1), 1'b0);
    drain(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
